// File: rtl/controller.sv
// rtl/controller.sv - Microsequencer FSM driving the datapath and memory strobes
//
// Purpose: fetches an instruction byte through PR, decodes the opcode held in
//   the datapath IR, and sequences operand fetch, memory read/write, ALU
//   execute and halt. Memory accesses wait for mem_ack with no timeout.
// Ports:
//   clk, reset          - system clock, asynchronous active-low reset
//   ir_code[7:0]        - IR contents: [7:4] opcode, [3:0] modifier
//   flag_z              - datapath zero flag (used by JZ)
//   mem_ack             - memory handshake, valid only in memory states
//   mem_rd, mem_wr      - memory request strobes
//   load_*/inc_pr       - register load / increment strobes
//   *_2_data            - data bus drive enables (at most one high)
//   ar_on_addr, pr_on_addr - address bus source (at most one high)
//   sub_nadd, add_oprnd1_sel, add_oprnd2_sel - ALU controls
//   halted              - high while in HALT

module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir_code,
  input  logic       flag_z,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ar,
  output logic       ar_on_addr,
  output logic       ar_2_data,
  output logic       load_dr,
  output logic       dr_2_data,
  output logic       load_lsb_gr,
  output logic       load_msb_gr,
  output logic       gr_2_data,
  output logic       load_ar_2_pr,
  output logic       inc_pr,
  output logic       pr_2_data,
  output logic       pr_on_addr,
  output logic       load_ir,
  output logic       ir_2_data,
  output logic       sub_nadd,
  output logic [1:0] add_oprnd1_sel,
  output logic [1:0] add_oprnd2_sel,
  output logic       alu_2_data,
  output logic       flag_2_data,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPER   = 3'd2,
    S_MEMRD  = 3'd3,
    S_MEMWR  = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDD = 4'h1;
  localparam logic [3:0] OP_STD = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_MVG = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] SEL_DR = 2'b01;
  localparam logic [1:0] SEL_GR = 2'b10;

  state_t     state, state_nxt;
  logic [3:0] opcode;
  logic       mvg_msb;
  logic       unused_mod_bits;

  assign opcode          = ir_code[7:4];
  assign mvg_msb         = ir_code[0];
  assign unused_mod_bits = ^ir_code[3:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are gated by reset so an in-flight access is dropped the moment
  // reset asserts, not at the next clock edge.
  always_comb begin
    state_nxt      = state;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    load_ar        = 1'b0;
    ar_on_addr     = 1'b0;
    ar_2_data      = 1'b0;
    load_dr        = 1'b0;
    dr_2_data      = 1'b0;
    load_lsb_gr    = 1'b0;
    load_msb_gr    = 1'b0;
    gr_2_data      = 1'b0;
    load_ar_2_pr   = 1'b0;
    inc_pr         = 1'b0;
    pr_2_data      = 1'b0;
    pr_on_addr     = 1'b0;
    load_ir        = 1'b0;
    ir_2_data      = 1'b0;
    sub_nadd       = 1'b0;
    add_oprnd1_sel = 2'b00;
    add_oprnd2_sel = 2'b00;
    alu_2_data     = 1'b0;
    flag_2_data    = 1'b0;
    halted         = 1'b0;

    if (reset) begin
      unique case (state)
        S_FETCH: begin
          pr_on_addr = 1'b1;
          mem_rd     = 1'b1;
          if (mem_ack) begin
            load_ir   = 1'b1;
            inc_pr    = 1'b1;
            state_nxt = S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_HLT:                         state_nxt = S_HALT;
            OP_ADD, OP_SUB, OP_MVG:         state_nxt = S_EXEC;
            OP_LDD, OP_STD, OP_JMP, OP_JZ:  state_nxt = S_OPER;
            default:                        state_nxt = S_FETCH;
          endcase
        end

        // Operand byte fetch: the byte is an address (LDD/STD) or a jump
        // target, so it always lands in AR or is steered into PR.
        S_OPER: begin
          pr_on_addr = 1'b1;
          mem_rd     = 1'b1;
          if (mem_ack) begin
            inc_pr = 1'b1;
            case (opcode)
              OP_LDD: begin
                load_ar   = 1'b1;
                state_nxt = S_MEMRD;
              end
              OP_STD: begin
                load_ar   = 1'b1;
                state_nxt = S_MEMWR;
              end
              OP_JMP: begin
                load_ar_2_pr = 1'b1;
                state_nxt    = S_FETCH;
              end
              OP_JZ: begin
                load_ar_2_pr = flag_z;
                state_nxt    = S_FETCH;
              end
              default: state_nxt = S_FETCH;
            endcase
          end
        end

        S_MEMRD: begin
          ar_on_addr = 1'b1;
          mem_rd     = 1'b1;
          if (mem_ack) begin
            load_dr   = 1'b1;
            state_nxt = S_FETCH;
          end
        end

        S_MEMWR: begin
          ar_on_addr = 1'b1;
          dr_2_data  = 1'b1;
          mem_wr     = 1'b1;
          if (mem_ack) begin
            state_nxt = S_FETCH;
          end
        end

        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              add_oprnd1_sel = SEL_DR;
              add_oprnd2_sel = SEL_GR;
              sub_nadd       = (opcode == OP_SUB);
              alu_2_data     = 1'b1;
              load_dr        = 1'b1;
            end
            OP_MVG: begin
              dr_2_data   = 1'b1;
              load_lsb_gr = !mvg_msb;
              load_msb_gr = mvg_msb;
            end
            default: ;
          endcase
          state_nxt = S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
        end

        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - Self-checking bench for the controller FSM
//
// Purpose: per-cycle vector table, hand sequences for wait states, halt and
//   asynchronous reset, and a randomized run scored per instruction against
//   an instruction-level model (latency, access count, strobe counts).
// Ports: none (top-level bench).

module tb_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir_code;
  logic       flag_z;
  logic       mem_ack;
  logic       mem_rd, mem_wr, load_ar, ar_on_addr, ar_2_data, load_dr, dr_2_data;
  logic       load_lsb_gr, load_msb_gr, gr_2_data, load_ar_2_pr, inc_pr, pr_2_data;
  logic       pr_on_addr, load_ir, ir_2_data, sub_nadd, alu_2_data, flag_2_data, halted;
  logic [1:0] add_oprnd1_sel, add_oprnd2_sel;

  always #5 clk = ~clk;

  controller dut (
    .clk(clk), .reset(reset), .ir_code(ir_code), .flag_z(flag_z), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ar(load_ar), .ar_on_addr(ar_on_addr),
    .ar_2_data(ar_2_data), .load_dr(load_dr), .dr_2_data(dr_2_data),
    .load_lsb_gr(load_lsb_gr), .load_msb_gr(load_msb_gr), .gr_2_data(gr_2_data),
    .load_ar_2_pr(load_ar_2_pr), .inc_pr(inc_pr), .pr_2_data(pr_2_data),
    .pr_on_addr(pr_on_addr), .load_ir(load_ir), .ir_2_data(ir_2_data),
    .sub_nadd(sub_nadd), .add_oprnd1_sel(add_oprnd1_sel), .add_oprnd2_sel(add_oprnd2_sel),
    .alu_2_data(alu_2_data), .flag_2_data(flag_2_data), .halted(halted)
  );

  logic [23:0] obs;
  assign obs = {halted, flag_2_data, alu_2_data, add_oprnd2_sel, add_oprnd1_sel, sub_nadd,
                ir_2_data, load_ir, pr_on_addr, pr_2_data, inc_pr, load_ar_2_pr, gr_2_data,
                load_msb_gr, load_lsb_gr, dr_2_data, load_dr, ar_2_data, ar_on_addr,
                load_ar, mem_wr, mem_rd};

  localparam logic [23:0] M_RD   = 24'd1 << 0;
  localparam logic [23:0] M_WR   = 24'd1 << 1;
  localparam logic [23:0] M_LAR  = 24'd1 << 2;
  localparam logic [23:0] M_ARA  = 24'd1 << 3;
  localparam logic [23:0] M_LDR  = 24'd1 << 5;
  localparam logic [23:0] M_DR2D = 24'd1 << 6;
  localparam logic [23:0] M_LLSB = 24'd1 << 7;
  localparam logic [23:0] M_LMSB = 24'd1 << 8;
  localparam logic [23:0] M_LA2P = 24'd1 << 10;
  localparam logic [23:0] M_INC  = 24'd1 << 11;
  localparam logic [23:0] M_PRA  = 24'd1 << 13;
  localparam logic [23:0] M_LIR  = 24'd1 << 14;
  localparam logic [23:0] M_SUB  = 24'd1 << 16;
  localparam logic [23:0] M_S1DR = 24'd1 << 17;
  localparam logic [23:0] M_S2GR = 24'd2 << 19;
  localparam logic [23:0] M_ALU  = 24'd1 << 21;
  localparam logic [23:0] M_HALT = 24'd1 << 23;

  localparam logic [23:0] E_F    = M_PRA | M_RD;
  localparam logic [23:0] E_FA   = E_F | M_LIR | M_INC;
  localparam logic [23:0] E_OA   = E_F | M_INC;
  localparam logic [23:0] E_ADD  = M_S1DR | M_S2GR | M_ALU | M_LDR;
  localparam logic [23:0] E_WR   = M_ARA | M_DR2D | M_WR;

  typedef struct {
    logic        rst;
    logic [7:0]  ir;
    logic        z;
    logic        ack;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   wleft   = 0;
  int   wait_cfg = 0;
  bit   rand_waits = 0;
  bit   rand_idle_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
  endtask

  function automatic void add(input logic r, input logic [7:0] ir, input logic z,
                              input logic a, input logic [23:0] e);
    vec_t v;
    v.rst = r; v.ir = ir; v.z = z; v.ack = a; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Memory responder: acks after a configured (or random) number of wait cycles.
  task automatic drive_ack();
    if (mem_rd || mem_wr) begin
      if (wleft == 0) begin
        mem_ack = 1'b1;
        wleft = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
      end else begin
        mem_ack = 1'b0;
        wleft--;
      end
    end else begin
      mem_ack = rand_idle_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_ack();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    wleft = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
  endtask

  function automatic bit inv_ok();
    int nbus;
    nbus = int'(pr_2_data) + int'(dr_2_data) + int'(gr_2_data) + int'(ar_2_data) +
           int'(alu_2_data) + int'(flag_2_data) + int'(ir_2_data);
    return (nbus <= 1) && !(ar_on_addr && pr_on_addr) && !(mem_rd && mem_wr) &&
           (alu_2_data || (add_oprnd1_sel == 2'b00 && add_oprnd2_sel == 2'b00));
  endfunction

  // Instruction-level model: cycles from this instruction's load_ir to the
  // next load_ir (zero-wait), acks taken, and strobe counts in that window.
  function automatic void model(input logic [7:0] ir, input logic z,
                                output int base, output int acc, output logic [26:0] strb);
    int lar, ldr, inc, la2p, alu, sub, lsb, msb, wra;
    lar = 0; ldr = 0; inc = 1; la2p = 0; alu = 0; sub = 0; lsb = 0; msb = 0; wra = 0;
    base = 2; acc = 1;
    case (ir[7:4])
      4'h1: begin base = 4; acc = 3; lar = 1; ldr = 1; inc = 2; end
      4'h2: begin base = 4; acc = 3; lar = 1; inc = 2; wra = 1; end
      4'h3: begin base = 3; ldr = 1; alu = 1; end
      4'h4: begin base = 3; ldr = 1; alu = 1; sub = 1; end
      4'h5: begin base = 3; lsb = ir[0] ? 0 : 1; msb = ir[0] ? 1 : 0; end
      4'h6: begin base = 3; acc = 2; inc = 2; la2p = 1; end
      4'h7: begin base = 3; acc = 2; inc = 2; la2p = z ? 1 : 0; end
      default: ;
    endcase
    strb = {3'(lar), 3'(ldr), 3'(inc), 3'(la2p), 3'(alu), 3'(sub), 3'(lsb), 3'(msb), 3'(wra)};
  endfunction

  initial begin
    reset = 1'b0; ir_code = 8'h00; flag_z = 1'b0; mem_ack = 1'b0;

    // ---- per-cycle vector table ----
    add(0, 8'h00, 0, 1, 24'd0);
    add(1, 8'h00, 0, 0, E_F);
    add(1, 8'h00, 0, 1, E_FA);
    add(1, 8'h00, 0, 1, 24'd0);        // DECODE NOP, stray ack ignored
    add(1, 8'h30, 0, 1, E_FA);
    add(1, 8'h30, 0, 1, 24'd0);
    add(1, 8'h30, 0, 1, E_ADD);        // EXEC ADD, stray ack ignored
    add(1, 8'h40, 0, 1, E_FA);
    add(1, 8'h40, 0, 0, 24'd0);
    add(1, 8'h40, 0, 0, E_ADD | M_SUB);
    add(1, 8'h51, 0, 1, E_FA);
    add(1, 8'h51, 0, 0, 24'd0);
    add(1, 8'h51, 0, 0, M_DR2D | M_LMSB);
    add(1, 8'h50, 0, 1, E_FA);
    add(1, 8'h50, 0, 0, 24'd0);
    add(1, 8'h50, 0, 0, M_DR2D | M_LLSB);
    add(1, 8'h10, 0, 1, E_FA);
    add(1, 8'h10, 0, 0, 24'd0);
    add(1, 8'h10, 0, 0, E_F);
    add(1, 8'h10, 0, 1, E_OA | M_LAR);
    add(1, 8'h10, 0, 0, M_ARA | M_RD);
    add(1, 8'h10, 0, 1, M_ARA | M_RD | M_LDR);
    add(1, 8'h20, 0, 1, E_FA);
    add(1, 8'h20, 0, 0, 24'd0);
    add(1, 8'h20, 0, 1, E_OA | M_LAR);
    add(1, 8'h20, 0, 0, E_WR);
    add(1, 8'h20, 0, 1, E_WR);
    add(1, 8'h70, 0, 1, E_FA);
    add(1, 8'h70, 0, 0, 24'd0);
    add(1, 8'h70, 0, 1, E_OA);         // JZ not taken
    add(1, 8'h70, 1, 1, E_FA);
    add(1, 8'h70, 1, 0, 24'd0);
    add(1, 8'h70, 1, 1, E_OA | M_LA2P); // JZ taken
    add(1, 8'h60, 0, 1, E_FA);
    add(1, 8'h60, 0, 0, 24'd0);
    add(1, 8'h60, 0, 1, E_OA | M_LA2P);
    add(1, 8'h90, 0, 1, E_FA);
    add(1, 8'h90, 0, 0, 24'd0);        // unassigned opcode -> FETCH
    add(1, 8'hF0, 0, 1, E_FA);
    add(1, 8'hF0, 0, 0, 24'd0);
    add(1, 8'hF0, 0, 1, M_HALT);
    add(1, 8'hF0, 0, 0, M_HALT);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; ir_code = tbl[i].ir; flag_z = tbl[i].z; mem_ack = tbl[i].ack;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // ---- NOP loop: one inc_pr per two cycles, no contention ----
    begin
      int incs;
      bit inv;
      incs = 0; inv = 1;
      ir_code = 8'h00; wait_cfg = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
        step();
        incs += int'(inc_pr);
        inv &= inv_ok();
      end
      chk("nop_inc_count", 32'(incs), 32'd10);
      chk("nop_invariants", 32'(inv), 32'd1);
    end

    // ---- LDD with 3 wait cycles on every access ----
    begin
      int c_lar, c_ldr, c_ir2, n_rd, n_ir;
      c_lar = 0; c_ldr = 0; c_ir2 = 0; n_rd = 0; n_ir = 0;
      ir_code = 8'h00; wait_cfg = 3;
      do_reset();
      for (int c = 1; c <= 60 && n_ir < 2; c++) begin
        step();
        n_rd += int'(mem_rd);
        if (load_ar) c_lar = c;
        if (load_dr) c_ldr = c;
        if (load_ir) begin
          n_ir++;
          ir_code = 8'h10;
          if (n_ir == 2) c_ir2 = c;
        end
      end
      chk("ldd_wait_load_ar_cycle", 32'(c_lar), 32'd9);
      chk("ldd_wait_load_dr_cycle", 32'(c_ldr), 32'd13);
      chk("ldd_wait_next_fetch", 32'(c_ir2), 32'd17);
      chk("ldd_wait_rd_cycles", 32'(n_rd), 32'd16);
    end

    // ---- HALT persists with mem_ack toggling ----
    ir_code = 8'hF0; wait_cfg = 0;
    do_reset();
    step();
    chk("halt_fetch", 32'(obs), 32'(E_FA));
    step();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ack = 1'(c % 2);
      #1;
      chk($sformatf("halt_hold%0d", c), 32'(obs), 32'(M_HALT));
    end

    // ---- reset asserted mid-MEMWR ----
    ir_code = 8'h20; wait_cfg = 0;
    do_reset();
    step();
    step();
    wait_cfg = 50;
    step();
    step();
    chk("memwr_before_reset", 32'(obs), 32'(E_WR));
    reset = 1'b0;
    #1;
    chk("memwr_async_drop", 32'(obs), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    wleft = 0;
    #1;
    chk("fetch_after_release", 32'(obs), 32'(E_F));

    // ---- randomized run scored per instruction ----
    begin
      logic [7:0]  cur_ir;
      logic        cur_z;
      bit          have_cur, inv;
      int          cyc, waits, acks, guard, ninstr, base, acc;
      int          lar, ldr, inc, la2p, alu, sub, lsb, msb, wra;
      logic [26:0] exp_strb, got_strb;
      cur_ir = 8'h00; cur_z = 1'b0; have_cur = 0; inv = 1;
      cyc = 0; waits = 0; acks = 0; guard = 0; ninstr = 0;
      lar = 0; ldr = 0; inc = 0; la2p = 0; alu = 0; sub = 0; lsb = 0; msb = 0; wra = 0;
      rand_waits = 1; rand_idle_ack = 1;
      ir_code = 8'h00;
      do_reset();
      while (ninstr < 150 && guard < 20000) begin
        guard++;
        step();
        inv &= inv_ok();
        cyc++;
        if ((mem_rd || mem_wr) && !mem_ack) waits++;
        if ((mem_rd || mem_wr) && mem_ack) acks++;
        lar += int'(load_ar); ldr += int'(load_dr); inc += int'(inc_pr);
        la2p += int'(load_ar_2_pr); alu += int'(alu_2_data); sub += int'(sub_nadd);
        lsb += int'(load_lsb_gr); msb += int'(load_msb_gr); wra += int'(mem_wr && mem_ack);
        if (load_ir) begin
          if (have_cur) begin
            model(cur_ir, cur_z, base, acc, exp_strb);
            got_strb = {3'(lar), 3'(ldr), 3'(inc), 3'(la2p), 3'(alu), 3'(sub),
                        3'(lsb), 3'(msb), 3'(wra)};
            chk($sformatf("rnd%0d_ir%02h_cycles", ninstr, cur_ir), 32'(cyc), 32'(base + waits));
            chk($sformatf("rnd%0d_ir%02h_acks", ninstr, cur_ir), 32'(acks), 32'(acc));
            chk($sformatf("rnd%0d_ir%02h_strobes", ninstr, cur_ir), 32'(got_strb), 32'(exp_strb));
            ninstr++;
          end
          have_cur = 1;
          cur_ir = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
          cur_z = 1'($urandom_range(0, 1));
          ir_code = cur_ir;
          flag_z = cur_z;
          cyc = 0; waits = 0; acks = 0;
          lar = 0; ldr = 0; inc = 0; la2p = 0; alu = 0; sub = 0; lsb = 0; msb = 0; wra = 0;
        end
      end
      chk("rnd_completed", 32'(ninstr), 32'd150);
      chk("rnd_invariants", 32'(inv), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
